// File: rtl/ascon_stream_collector_if.sv
// ascon_stream_collector_if: serial capture inputs and word-drain handshake of the collector
interface ascon_stream_collector_if #(parameter int WORD = 32);
  logic start;
  logic ready_in;
  logic ct_bit;
  logic tag_bit;
  logic out_ready;
  logic [WORD-1:0] out_data;
  logic out_valid;
  logic out_kind;
  logic out_last;
  logic busy;
  logic overrun;
  modport master(
    output start, ready_in, ct_bit, tag_bit, out_ready,
    input out_data, out_valid, out_kind, out_last, busy, overrun
  );
  modport slave(
    input start, ready_in, ct_bit, tag_bit, out_ready,
    output out_data, out_valid, out_kind, out_last, busy, overrun
  );
endinterface

// File: rtl/ascon_stream_collector.sv
// ascon_stream_collector: deserialises Ascon ciphertext/tag bit streams into WORD-bit handshaked words
module ascon_stream_collector #(
  parameter int CT_BITS  = 64,
  parameter int TAG_BITS = 128,
  parameter int WORD     = 32
) (
  input logic clk,
  input logic rst,
  ascon_stream_collector_if.slave bus
);
  localparam int CT_W = CT_BITS / WORD;
  localparam int NW   = (CT_BITS + TAG_BITS) / WORD;
  localparam int CW   = $clog2(TAG_BITS + 1);
  localparam int IW   = $clog2(NW + 1);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_widx;
  logic [CT_BITS-1:0] r_ct_sr, w_ct_sh;
  logic [TAG_BITS-1:0] r_tag_sr, w_tag_sh;
  logic r_overrun, w_drain, w_accept, w_final, w_shift, w_kind;
  assign w_drain  = r_state == DRAIN;
  assign w_accept = w_drain && bus.out_ready;
  assign w_final  = w_accept && r_widx == IW'(NW - 1);
  assign w_shift  = (r_state == ARMED && bus.ready_in) || r_state == CAPTURE;
  assign w_kind   = w_drain && r_widx >= IW'(CT_W);
  // Word selection: shift the chosen word up to the MSB end, then take the top WORD bits
  assign w_ct_sh  = r_ct_sr << (WORD * r_widx);
  assign w_tag_sh = r_tag_sr << (WORD * (r_widx - IW'(CT_W)));
  assign bus.out_valid = w_drain;
  assign bus.out_kind  = w_kind;
  assign bus.out_last  = w_drain && r_widx == IW'(NW - 1);
  assign bus.out_data  = !w_drain ? '0 : w_kind ? w_tag_sh[TAG_BITS-1 -: WORD] : w_ct_sh[CT_BITS-1 -: WORD];
  assign bus.busy      = r_state != IDLE;
  assign bus.overrun   = r_overrun;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.start ? ARMED : IDLE;
      ARMED:   w_next = bus.ready_in ? CAPTURE : ARMED;
      CAPTURE: w_next = r_cnt == CW'(TAG_BITS - 1) ? DRAIN : CAPTURE;
      DRAIN:   w_next = w_final ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_widx    <= '0;
      r_ct_sr   <= '0;
      r_tag_sr  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_next;
      if (bus.start) r_overrun <= r_state != IDLE;
      if (r_state == IDLE && bus.start) r_cnt <= '0;
      if (w_shift) begin
        r_tag_sr <= {r_tag_sr[TAG_BITS-2:0], bus.tag_bit};
        r_cnt    <= r_cnt + 1'b1;
      end
      if (w_shift && r_cnt < CW'(CT_BITS)) r_ct_sr <= {r_ct_sr[CT_BITS-2:0], bus.ct_bit};
      if (w_accept) r_widx <= w_final ? '0 : r_widx + 1'b1;
    end
  end
endmodule

// File: tb/tb_ascon_stream_collector.sv
// tb_ascon_stream_collector: randomized sessions against a word-list reference model, default and 128/128 configurations
module tb_ascon_stream_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic start_a = 1'b0, start_b = 1'b0, ready_in = 1'b0, ct_bit = 1'b0, tag_bit = 1'b0, out_ready = 1'b0, sel = 1'b0;
  int checks = 0, failures = 0;
  ascon_stream_collector_if #(.WORD(32)) bus_a();
  ascon_stream_collector_if #(.WORD(32)) bus_b();
  assign bus_a.start = start_a;
  assign bus_b.start = start_b;
  assign bus_a.ready_in = ready_in;
  assign bus_b.ready_in = ready_in;
  assign bus_a.ct_bit = ct_bit;
  assign bus_b.ct_bit = ct_bit;
  assign bus_a.tag_bit = tag_bit;
  assign bus_b.tag_bit = tag_bit;
  assign bus_a.out_ready = out_ready;
  assign bus_b.out_ready = out_ready;
  ascon_stream_collector dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  ascon_stream_collector #(.CT_BITS(128), .TAG_BITS(128), .WORD(32)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  logic [31:0] d;
  logic v, k, l, b, o;
  assign d = sel ? bus_b.out_data : bus_a.out_data;
  assign v = sel ? bus_b.out_valid : bus_a.out_valid;
  assign k = sel ? bus_b.out_kind : bus_a.out_kind;
  assign l = sel ? bus_b.out_last : bus_a.out_last;
  assign b = sel ? bus_b.busy : bus_a.busy;
  assign o = sel ? bus_b.overrun : bus_a.overrun;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      checks++;
      if ({d, v, k, l, b, o} !== 37'd0) begin
        failures++;
        $display("FAIL reset sel=%0d got data=%h v=%b k=%b l=%b busy=%b ovr=%b expected all 0", s, d, v, k, l, b, o);
      end
    end
    sel = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  // Drives one full session; the expected word list is built from the stream values alone.
  task automatic run_session(input string name, input int n_ct, input logic [127:0] ct, input logic [127:0] tag,
                             input int gap, input bit bp, input int ovr_at, input bit start_on_last, input int abort_n);
    logic [33:0] exp_q[$];
    logic [33:0] held;
    int nw, n, cyc, stalled;
    bit hold, exp_ovr;
    nw = (n_ct + 128) / 32;
    n = 0; cyc = 0; stalled = 0; hold = 0; exp_ovr = 0; held = '0;
    for (int i = 0; i < nw; i++) begin
      logic [127:0] t;
      t = (i < n_ct / 32) ? ct >> (n_ct - 32 * (i + 1)) : tag >> (128 - 32 * (i - n_ct / 32 + 1));
      exp_q.push_back({1'(i == nw - 1), 1'(i >= n_ct / 32), t[31:0]});
    end
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    checks++;
    if (b !== 1'b1 || o !== 1'b0) begin
      failures++;
      $display("FAIL %s start busy=%b ovr=%b expected busy=1 ovr=0", name, b, o);
    end
    repeat (gap) tick();
    for (int i = 0; i < 128; i++) begin
      ready_in = (i == 0) ? 1'b1 : 1'($urandom);
      ct_bit = (i < n_ct) ? ct[n_ct - 1 - i] : 1'($urandom);
      tag_bit = tag[127 - i];
      if (i == ovr_at) begin
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        exp_ovr = 1;
      end
      tick();
      start_a = 1'b0; start_b = 1'b0;
      checks++;
      if (v !== (i == 127)) begin
        failures++;
        $display("FAIL %s valid_timing T+%0d got=%b expected=%b", name, i + 1, v, i == 127);
      end
    end
    ready_in = 1'b0;
    checks++;
    if (o !== exp_ovr) begin
      failures++;
      $display("FAIL %s overrun_capture got=%b expected=%b", name, o, exp_ovr);
    end
    while (n < nw && cyc < 400) begin
      if (n == abort_n) begin
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({d, v, k, l, b, o} !== 37'd0) begin
          failures++;
          $display("FAIL %s async_abort got data=%h v=%b k=%b l=%b busy=%b ovr=%b expected all 0", name, d, v, k, l, b, o);
        end
        rst = 1'b0;
        tick();
        return;
      end
      if (bp && n == 3 && stalled < 5) begin
        out_ready = 1'b0;
        stalled++;
      end else out_ready = bp ? 1'(cyc) : 1'b1;
      if (hold) begin
        checks++;
        if ({l, k, d} !== held) begin
          failures++;
          $display("FAIL %s stall_stable got=%h expected=%h", name, {l, k, d}, held);
        end
      end
      checks++;
      if (v !== 1'b1) begin
        failures++;
        $display("FAIL %s drain_valid word=%0d got=%b expected=1", name, n, v);
      end
      if (v && out_ready) begin
        checks++;
        if ({l, k, d} !== exp_q[n]) begin
          failures++;
          $display("FAIL %s word%0d got last=%b kind=%b data=%h expected last=%b kind=%b data=%h",
                   name, n, l, k, d, exp_q[n][33], exp_q[n][32], exp_q[n][31:0]);
        end
        n++;
        if (start_on_last && n == nw) begin
          if (sel) start_b = 1'b1; else start_a = 1'b1;
          exp_ovr = 1;
        end
      end
      hold = v && !out_ready;
      held = {l, k, d};
      cyc++;
      tick();
      start_a = 1'b0; start_b = 1'b0;
    end
    out_ready = 1'b0;
    checks++;
    if (n != nw || b !== 1'b0 || v !== 1'b0 || o !== exp_ovr || (!bp && cyc != nw)) begin
      failures++;
      $display("FAIL %s completion got words=%0d cycles=%0d busy=%b valid=%b ovr=%b expected words=%0d busy=0 valid=0 ovr=%b",
               name, n, cyc, b, v, o, nw, exp_ovr);
    end
  endtask

  task automatic test_basic;
    run_session("basic", 64, 128'hDEADBEEF_01234567, 128'h00112233_44556677_8899AABB_CCDDEEFF, 3, 0, -1, 0, -1);
  endtask

  task automatic test_backpressure;
    run_session("backpressure", 64, {64'd0, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                int'($urandom_range(0, 4)), 1, -1, 0, -1);
  endtask

  task automatic test_spurious;
    for (int i = 0; i < 12; i++) begin
      ready_in = 1'($urandom);
      ct_bit = 1'($urandom);
      tag_bit = 1'($urandom);
      tick();
      checks++;
      if (b !== 1'b0 || v !== 1'b0) begin
        failures++;
        $display("FAIL spurious cycle%0d got busy=%b valid=%b expected 0 0", i, b, v);
      end
    end
    ready_in = 1'b0;
  endtask

  task automatic test_overrun;
    run_session("overrun", 64, {64'd0, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1, 0, 40, 1, -1);
    run_session("overrun_clear", 64, {64'd0, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, 0, -1, 0, -1);
  endtask

  task automatic test_reset_mid_drain;
    run_session("abort", 64, {64'd0, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 2, 0, -1, 0, 2);
    run_session("after_abort", 64, {64'd0, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 2, 1, -1, 0, -1);
  endtask

  task automatic test_param_variant;
    sel = 1'b1;
    #1;
    run_session("variant_alt", 128, {4{32'hAAAAAAAA}}, {4{32'h55555555}}, 1, 0, -1, 0, -1);
    run_session("variant_rand", 128, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                2, 1, -1, 0, -1);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_spurious();
    test_overrun();
    test_reset_mid_drain();
    test_param_variant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ascon_stream_collector.md
# ascon_stream_collector

Bit-serial result collector for the Ascon core in the user project area. It captures the ciphertext and tag streams that the core shifts out after `encryption_readyxSO` rises, deserialises them, and presents them as `WORD`-bit words over a valid/ready handshake. Downstream logic, such as a Wishbone readback register or an IO shifter, drains those words. It is the receiving end of the core's serial output interface.

## Interface
Parameters:
- `CT_BITS`, default 64: ciphertext length in bits. Must be a multiple of `WORD`, must be ≤ `TAG_BITS`.
- `TAG_BITS`, default 128: tag length in bits. Must be a multiple of `WORD`.
- `WORD`, default 32: output word width.

Ports:
- `clk` input 1: single clock, driven from `wb_clk_i`.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle pulse, issued together with `encryption_startxSI`, that arms a capture session.
- `ready_in` input 1: `encryption_readyxSO` from the core.
- `ct_bit` input 1: `cipher_textxSO` from the core.
- `tag_bit` input 1: `tagxSO` from the core.
- `out_data` output `WORD`: current output word.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: downstream accepts the word.
- `out_kind` output 1: 0 = ciphertext word, 1 = tag word.
- `out_last` output 1: final word of the session.
- `busy` output 1: state is not IDLE.
- `overrun` output 1: sticky flag, set when `start` arrives while busy.

## Operation
- **Stream format (decided):**
  - The core drives bit 0 of both streams in the first cycle `ready_in` is high.
  - After that, one bit per cycle, MSB first.
  - The ciphertext stream lasts `CT_BITS` cycles; the tag stream lasts `TAG_BITS` cycles. Both start in the same cycle.
  - `ct_bit` is don't-care after `CT_BITS` cycles.
- **State IDLE:**
  - `start` → ARMED.
  - `ready_in` is ignored.
- **State ARMED:**
  - The first cycle with `ready_in` = 1 is capture cycle 0. The bits are shifted in that cycle, and the state moves to CAPTURE with `cnt` = 1.
  - `ready_in` need not stay high after capture cycle 0.
- **State CAPTURE:**
  - Each cycle, `tag_sr` ← {`tag_sr`, `tag_bit`}.
  - `ct_sr` ← {`ct_sr`, `ct_bit`} only while `cnt` < `CT_BITS`.
  - `cnt` increments each cycle.
  - When `cnt` == `TAG_BITS` - 1 (last bit shifted in), go to DRAIN with `widx` = 0.
- **State DRAIN:**
  - `out_valid` = 1.
  - Word `widx` < `CT_BITS`/`WORD` is ciphertext word `widx`, MSB-aligned (word 0 = `ct_sr[CT_BITS-1 -: WORD]`), with `out_kind` = 0.
  - Remaining words are tag words, taken the same way from `tag_sr`, with `out_kind` = 1.
  - `out_last` = 1 only on word (`CT_BITS`+`TAG_BITS`)/`WORD` - 1.
  - On `out_valid` && `out_ready`, `widx` increments.
  - When the last word is accepted, go to IDLE.
- **`start` while busy:** the pulse is ignored for control and sets `overrun`. `overrun` clears only on `rst` or on a `start` accepted in IDLE.
- **Handshake rule:** `out_data`, `out_kind` and `out_last` hold stable while `out_valid` && !`out_ready`.
- **Reset:**
  - Values: state = IDLE, `cnt` = 0, `widx` = 0, shift registers = 0, `out_valid` = 0, `out_last` = 0, `out_kind` = 0, `out_data` = 0, `busy` = 0, `overrun` = 0.
  - Asserting `rst` mid-capture or mid-drain aborts the session immediately. Partial words are discarded.

## Timing
- Let T = the cycle in which ARMED samples `ready_in` = 1.
- Last tag bit is sampled at T + `TAG_BITS` - 1.
- `out_valid` rises at T + `TAG_BITS` (registered). With `TAG_BITS` = 128, that is T + 128.
- With `out_ready` tied to 1, one word transfers per cycle. Six words (2 ct + 4 tag at the defaults) occupy T+128 … T+133; `busy` = 0 from T+134.
- `start` accepted in IDLE at cycle S makes `busy` = 1 at S+1. `ready_in` sampled at S+1 or later counts.
- Same-cycle `start` and final-word acceptance: the FSM goes to IDLE, `start` counts as busy, and `overrun` is set.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to `out_valid`.

## Test plan
- **Basic session:** defaults; `start`; 3 idle cycles; `ready_in` high; stream ct = 0xDEADBEEF_01234567 and tag = 0x00112233_44556677_8899AABB_CCDDEEFF, MSB first; `out_ready` = 1 → words DEADBEEF, 01234567 (`kind` 0), then 00112233, 44556677, 8899AABB, CCDDEEFF (`kind` 1). `out_last` on CCDDEEFF only. `out_valid` first at T+128.
- **Backpressure:** as the basic session, but toggle `out_ready` 0/1 every cycle and hold it 0 for 5 cycles on word 3 → `out_data` stable while stalled, and exactly 6 transfers in order.
- **Spurious ready:** `ready_in` pulsed in IDLE with no `start` → `busy` stays 0, `out_valid` stays 0.
- **Overrun:** `start` pulsed during CAPTURE at cnt = 40 → `overrun` = 1 and the session completes with correct data. The next `start` in IDLE clears `overrun`.
- **Reset mid-drain:** assert `rst` after word 2 is accepted → all outputs 0 in the same cycle (async). A fresh session then returns correct words.
- **Parameter variant:** `CT_BITS` = 128, `TAG_BITS` = 128, alternating-bit patterns → 8 words, 4 ct then 4 tag, matching the injected bits.
